// File: rtl/fifo_pkt_reader.sv
// Drain-side packet framer for the 72-bit FIFO: issues reads, absorbs read latency in a 2-entry skid buffer.
// Optional packet length check is built when PKT_READER_LEN_CHECK_EN is defined.
module fifo_pkt_reader #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int WIDTH         = DATA_WIDTH + CTRL_WIDTH,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fiforead,
  input  logic                  empty,
  input  logic [WIDTH-1:0]      out_fifo,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [15:0]           pkt_count,
  output logic                  err_drop,
  output logic                  err_len
);

  typedef enum logic [1:0] {IDLE = 2'd0, IN_PKT = 2'd1, DROP = 2'd2} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  sop;
    logic                  eop;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      buf_q [2];
  entry_t      buf_d [2];
  entry_t      new_e;
  logic [1:0]  occ_q, occ_d;
  logic [1:0]  eff_occ;
  logic        inflight_q, inflight_d;
  logic        run_q;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        err_drop_q, err_drop_d;
  logic        pop, push, push_sop, push_eop, drop, is_delim, wr_idx;
  logic [CTRL_WIDTH-1:0] word_ctrl;

  assign word_ctrl = out_fifo[WIDTH-1:DATA_WIDTH];
  assign is_delim  = |word_ctrl;

  assign out_vld = (occ_q != 2'd0);
  assign pop     = out_vld & out_rdy;

  // The word leaving this cycle frees its slot, which keeps one read per cycle going.
  assign eff_occ    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign fiforead   = run_q & ~empty & (eff_occ < 2'd2);
  assign inflight_d = fiforead;

`ifdef PKT_READER_LEN_CHECK_EN
  localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err, err_len_q, err_len_d, too_long;

  // A body word at MAX-1 would leave no room for the closing delimiter.
  assign too_long = (cnt_q >= CNT_W'(MAX_PKT_WORDS - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (inflight_q) begin
      unique case (state_q)
        IDLE:   if (is_delim) state_d = IN_PKT;
        IN_PKT: begin
          if (is_delim) state_d = IDLE;
`ifdef PKT_READER_LEN_CHECK_EN
          else if (too_long) state_d = DROP;
`endif
        end
        DROP:    if (is_delim) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push     = 1'b0;
    push_sop = 1'b0;
    push_eop = 1'b0;
    drop     = 1'b0;
`ifdef PKT_READER_LEN_CHECK_EN
    len_err  = 1'b0;
`endif
    if (inflight_q) begin
      unique case (state_q)
        IDLE: begin
          if (is_delim) begin
            push     = 1'b1;
            push_sop = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
        IN_PKT: begin
          if (is_delim) begin
            push     = 1'b1;
            push_eop = 1'b1;
          end
`ifdef PKT_READER_LEN_CHECK_EN
          else if (too_long) begin
            drop    = 1'b1;
            len_err = 1'b1;
          end
`endif
          else begin
            push = 1'b1;
          end
        end
        default: drop = 1'b1;
      endcase
    end
  end

  assign new_e  = '{data: out_fifo[DATA_WIDTH-1:0], ctrl: word_ctrl, sop: push_sop, eop: push_eop};
  assign wr_idx = pop ? occ_q[1] : occ_q[0];

  always_comb begin
    buf_d = buf_q;
    if (pop)  buf_d[0] = buf_q[1];
    if (push) buf_d[wr_idx] = new_e;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    pkt_count_d = pkt_count_q + {15'd0, pop & buf_q[0].eop};
    err_drop_d  = drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      run_q       <= 1'b0;
      pkt_count_q <= 16'd0;
      err_drop_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) buf_q[i] <= buf_d[i];
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      run_q       <= 1'b1;
      pkt_count_q <= pkt_count_d;
      err_drop_q  <= err_drop_d;
    end
  end

`ifdef PKT_READER_LEN_CHECK_EN
  always_comb begin
    cnt_d = cnt_q;
    if (push) cnt_d = push_sop ? CNT_W'(1) : cnt_q + 1'b1;
    err_len_d = len_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_len_q <= err_len_d;
    end
  end

  assign err_len = err_len_q;
`else
  assign err_len = 1'b0;
`endif

  assign out_data  = buf_q[0].data;
  assign out_ctrl  = buf_q[0].ctrl;
  assign out_sop   = buf_q[0].sop;
  assign out_eop   = buf_q[0].eop;
  assign pkt_count = pkt_count_q;
  assign err_drop  = err_drop_q;

endmodule
